// File: rtl/spike_out_wb_master.sv
// Spike word FIFO feeding single-beat Wishbone write cycles to a fixed address.
// Ports: wb_clk_i/wb_rst_i; spike_* and enable_i (core side); wbm_* (bus); busy/err/counters.
module spike_out_wb_master #(
    parameter logic [31:0] TARGET_ADDR = 32'h30008000,
    parameter int          TIMEOUT     = 255,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] spike_data_i,
    input  logic        spike_valid_i,
    output logic        spike_ready_o,
    input  logic        enable_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [15:0] sent_count_o,
    output logic [7:0]  drop_count_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUS} state_t;

    state_t state_q, state_d;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;

    logic [WW-1:0] wait_q, wait_d;
    logic          cyc_d, stb_d, we_d;
    logic [3:0]    sel_d;
    logic [31:0]   adr_d, dat_d;
    logic          ack_done, tmo;

    // Read data is never used by a write-only master.
    logic unused_dat;
    assign unused_dat = ^wbm_dat_i;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full          = (count == CW'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign spike_ready_o = !full;
    assign push          = spike_valid_i && !full;
    assign pop           = ack_done || tmo;
    assign busy_o        = !empty || wbm_cyc_o;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        cyc_d    = wbm_cyc_o;
        stb_d    = wbm_stb_o;
        we_d     = wbm_we_o;
        sel_d    = wbm_sel_o;
        adr_d    = wbm_adr_o;
        dat_d    = wbm_dat_o;
        ack_done = 1'b0;
        tmo      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // cyc is always low here, so every cycle gets a one-cycle gap.
                if (enable_i && !empty && !wbm_cyc_o) begin
                    state_d = BUS;
                    wait_d  = '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    sel_d   = 4'hF;
                    adr_d   = TARGET_ADDR;
                    dat_d   = mem[rd_ptr];
                end
            end
            BUS: begin
                // Ack wins over a timeout landing in the same cycle.
                if (wbm_ack_i) begin
                    ack_done = 1'b1;
                end else if (wait_q == WW'(TIMEOUT)) begin
                    tmo = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
                if (ack_done || tmo) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'h0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
            wbm_sel_o    <= 4'h0;
            wbm_adr_o    <= 32'h0;
            wbm_dat_o    <= 32'h0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_o        <= 1'b0;
            sent_count_o <= 16'h0;
            drop_count_o <= 8'h0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            wbm_cyc_o <= cyc_d;
            wbm_stb_o <= stb_d;
            wbm_we_o  <= we_d;
            wbm_sel_o <= sel_d;
            wbm_adr_o <= adr_d;
            wbm_dat_o <= dat_d;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            err_o <= tmo;
            if (ack_done) begin
                sent_count_o <= sent_count_o + 16'd1;
            end
            if (tmo && drop_count_o != 8'hFF) begin
                drop_count_o <= drop_count_o + 8'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push && !wb_rst_i) begin
            mem[wr_ptr] <= spike_data_i;
        end
    end

endmodule
